// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the memory-side stage of the multicycle MIPS core.
package mips_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} memif_state_t;
  localparam logic [1:0] LB_WORD = 2'b00;
  localparam logic [1:0] LB_BYTE = 2'b01;
  localparam logic [1:0] LB_BYTEU = 2'b10;
  localparam logic [31:0] MEM_TIMEOUT_FILL = 32'hDEAD_BEEF;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte lane and sign/zero-extends it for byte loads; words pass through.
import mips_pkg::*;
module load_align (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_adr,
  input  logic [1:0]  i_lb,
  output logic [31:0] o_data
);
  logic [7:0] w_b;
  assign w_b = i_rdata[{i_adr, 3'b000} +: 8];
  assign o_data = i_lb == LB_BYTE ? {{24{w_b[7]}}, w_b} : i_lb == LB_BYTEU ? {24'd0, w_b} : i_rdata;
endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: runs one req/ack bus transfer per core access, stalling the controller meanwhile.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
import mips_pkg::*;
module mem_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_rd,
  input  logic          memwrite,
  input  logic [1:0]    lb,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_adr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_be,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          bus_err
);
  memif_state_t r_state, w_next;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata, r_readdata, w_align;
  logic [1:0] r_lb;
  logic r_we;
  logic [3:0] r_be;
  logic w_start, w_ack, w_to;
  // Gating with reset keeps stall low while the core is being reset mid-access
  assign w_start = !reset && r_state == IDLE && (mem_rd || memwrite);
  assign w_ack = r_state == REQ && bus_ack;
  assign w_next = w_start ? REQ : (w_ack || w_to) ? DONE : r_state == DONE ? IDLE : r_state;
  load_align u_align (
    .i_rdata(bus_rdata),
    .i_adr  (r_adr[1:0]),
    .i_lb   (r_lb),
    .o_data (w_align)
  );
`ifdef MEM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wd;
  logic r_err;
  assign w_to = r_state == REQ && !bus_ack && r_wd == WW'(TIMEOUT - 1);
  assign bus_err = r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd <= r_state == REQ ? r_wd + 1'b1 : '0;
      if (w_to) r_err <= 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
  assign bus_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_adr <= '0;
      r_wdata <= '0;
      r_lb <= LB_WORD;
      r_we <= 1'b0;
      r_be <= 4'h0;
      r_readdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_adr <= adr;
        r_wdata <= writedata;
        r_lb <= lb;
        r_we <= memwrite;
        r_be <= 4'hF;
      end
      if (w_ack && !r_we) r_readdata <= w_align;
      else if (w_to && !r_we) r_readdata <= MEM_TIMEOUT_FILL;
    end
  end
  assign bus_req = r_state == REQ;
  assign stall = w_start || bus_req;
  assign bus_we = r_we;
  assign bus_adr = {r_adr[AW-1:2], 2'b00};
  assign bus_wdata = r_wdata;
  assign bus_be = r_be;
  assign readdata = r_readdata;
endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed and randomized accesses checked against a byte-level load model.
module tb_mem_bus_if;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_rd = 1'b0, memwrite = 1'b0, bus_ack = 1'b0;
  logic [1:0] lb = 2'b00;
  logic [31:0] adr = '0, writedata = '0, bus_rdata = '0;
  logic [31:0] readdata, bus_adr, bus_wdata;
  logic stall, bus_req, bus_we, bus_err;
  logic [3:0] bus_be;
  int checks = 0, errors = 0;
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  mem_bus_if #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .memwrite(memwrite), .lb(lb), .adr(adr),
    .writedata(writedata), .readdata(readdata), .stall(stall), .bus_req(bus_req),
    .bus_we(bus_we), .bus_adr(bus_adr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [1:0] t);
    logic [31:0] b;
    b = (w >> (8 * (a % 4))) & 32'd255;
    if (t == 2'b01) return b >= 128 ? b + 32'hFFFF_FF00 : b;
    if (t == 2'b10) return b;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle, ends in the DONE cycle with the request left as given
  task automatic access(input logic rd, input logic wr, input logic [1:0] t, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rv, input int waits);
    int st;
    mem_rd = rd; memwrite = wr; lb = t; adr = a; writedata = wd;
    #1;
    chk("idle_stall", stall, 1);
    chk("idle_req", bus_req, 0);
    st = stall ? 1 : 0;
    tick();
    for (int i = 0; i <= waits; i++) begin
      chk("req", bus_req, 1);
      chk("adr", bus_adr, a & 32'hFFFF_FFFC);
      chk("we", bus_we, wr);
      chk("be", bus_be, 4'hF);
      if (wr) chk("wdata", bus_wdata, wd);
      st += stall ? 1 : 0;
      bus_ack = (i == waits);
      bus_rdata = (i == waits) ? rv : $urandom;
      tick();
    end
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    if (!wr) exp_rd = ref_load(rv, a, t);
    chk("done_stall", stall, 0);
    chk("done_req", bus_req, 0);
    chk("readdata", readdata, exp_rd);
    chk("stall_cycles", st, waits + 2);
  endtask

  initial begin
    #1;
    chk("rst_req", bus_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_adr", bus_adr, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_err", bus_err, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_nostall", stall, 0);
    // Word read, 3 wait cycles
    access(1, 0, 2'b00, 32'h40, 32'h0, 32'h1234_5678, 3);
    mem_rd = 0; tick();
    // Signed and unsigned byte loads from the top lane
    access(1, 0, 2'b01, 32'h43, 32'h0, 32'h80FF_0011, 1);
    chk("lb_signed", readdata, 32'hFFFF_FF80);
    mem_rd = 0; tick();
    access(1, 0, 2'b10, 32'h43, 32'h0, 32'h80FF_0011, 0);
    chk("lbu", readdata, 32'h0000_0080);
    mem_rd = 0; tick();
    // Write keeps readdata, aligns address
    access(0, 1, 2'b00, 32'h1002, 32'hCAFE_F00D, 32'h5555_AAAA, 2);
    memwrite = 0; tick();
    // Ack while idle is ignored
    bus_ack = 1; bus_rdata = 32'h0BAD_0BAD; tick();
    bus_ack = 0;
    chk("stray_ack_req", bus_req, 0);
    chk("stray_ack_data", readdata, exp_rd);
    // Back-to-back: read held through DONE, then write
    access(1, 0, 2'b00, 32'h80, 32'h0, 32'hA5A5_0001, 0);
    tick();
    access(0, 1, 2'b00, 32'h84, 32'h1111_2222, 32'h0, 1);
    memwrite = 0; tick();
    // Both strobes: write wins
    access(1, 1, 2'b00, 32'h88, 32'h3333_4444, 32'h7777_7777, 0);
    chk("rw_readdata", readdata, 32'hA5A5_0001);
    mem_rd = 0; memwrite = 0; tick();
    // Reset during REQ
    mem_rd = 1; adr = 32'h200; lb = 2'b00; tick();
    chk("pre_rst_req", bus_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", bus_req, 0);
    chk("async_rst_stall", stall, 0);
    exp_rd = '0;
    tick();
    reset = 1'b0; mem_rd = 0; bus_ack = 1; bus_rdata = 32'hFEED_FACE;
    tick();
    bus_ack = 0;
    chk("late_ack_req", bus_req, 0);
    chk("late_ack_stall", stall, 0);
    chk("late_ack_data", readdata, exp_rd);
    tick();
    chk("after_rst_idle", bus_req, 0);
    // Randomized accesses against the model
    for (int n = 0; n < 24; n++) begin
      logic w;
      w = ($urandom % 3) == 0;
      access(!w, w, 2'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom % 2) begin mem_rd = 0; memwrite = 0; end
      tick();
      mem_rd = 0; memwrite = 0;
    end
`ifdef MEM_TIMEOUT_EN
    begin
      int cyc;
      mem_rd = 1; lb = 2'b00; adr = 32'h300;
      tick();
      cyc = 0;
      while (bus_req && cyc < 20) begin cyc++; tick(); end
      mem_rd = 0;
      chk("timeout_cycles", cyc, 4);
      chk("timeout_err", bus_err, 1);
      chk("timeout_data", readdata, 32'hDEAD_BEEF);
      tick();
      chk("err_sticky", bus_err, 1);
    end
`else
    chk("err_tied", bus_err, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
